dpic_mem_arbiter: RTL

- Shares the single DPI-C simulation memory port between instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Arbitrates, sequences one access at a time through a fixed IDLE→ACCESS→RESP flow, and drives the memory's rd/we signals as clean registered single-cycle pulses.
- Returns registered responses over valid/ready handshakes.
- Sits between the core pipeline and the dpic_memory instance.

---
 rtl/dpic_mem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dpic_mem_arbiter.sv
// dpic_mem_arbiter: shares the single DPI-C memory port between instruction fetch and load/store.
// One access at a time; memory strobes and responses all come straight from registers.
//
// state  | meaning
// IDLE   | grant one requester (LS first unless IF has been passed over STARVE_MAX times)
// ACCESS | single-cycle memory strobe; read data captured at the end of the cycle
// RESP   | response held for the winner until it is consumed
module dpic_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic              ls_req_wen,
    input  logic [DATA_W-1:0] ls_req_wdata,
    input  logic [7:0]        ls_req_wmask,
    output logic              ls_resp_valid,
    input  logic              ls_resp_ready,
    output logic [DATA_W-1:0] ls_resp_data,
    output logic              ls_resp_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_we_en,
    output logic [ADDR_W-1:0] mem_we_addr,
    output logic [DATA_W-1:0] mem_we_data,
    output logic [7:0]        mem_we_mask
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       acc_if;
    logic       acc_rd;
    logic       acc_err;

    logic idle;
    logic if_win;
    logic ls_win;
    logic mask_ok;
    logic consume;

    // Ready is gated by reset so nothing is offered while reset is held.
    assign idle    = (state == IDLE) && reset;
    assign if_win  = if_req_valid && (!ls_req_valid || (starve_cnt == STARVE_LIM));
    assign ls_win  = ls_req_valid && !if_win;
    assign if_req_ready = idle && if_win;
    assign ls_req_ready = idle && ls_win;
    assign mask_ok = (ls_req_wmask == 8'h01) || (ls_req_wmask == 8'h03) ||
                     (ls_req_wmask == 8'h0F) || (ls_req_wmask == 8'hFF);
    assign consume = (if_resp_valid && if_resp_ready) || (ls_resp_valid && ls_resp_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            acc_if        <= 1'b0;
            acc_rd        <= 1'b0;
            acc_err       <= 1'b0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
            ls_resp_err   <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_rd_addr   <= '0;
            mem_we_en     <= 1'b0;
            mem_we_addr   <= '0;
            mem_we_data   <= '0;
            mem_we_mask   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req_ready || ls_req_ready) begin
                        acc_if <= if_win;
                        if (if_win) begin
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= if_req_addr;
                            acc_rd      <= 1'b1;
                            acc_err     <= 1'b0;
                        end else if (!ls_req_wen) begin
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= ls_req_addr;
                            acc_rd      <= 1'b1;
                            acc_err     <= 1'b0;
                        end else begin
                            // An illegal mask never reaches the memory; it only flags err.
                            acc_rd  <= 1'b0;
                            acc_err <= !mask_ok;
                            if (mask_ok) begin
                                mem_we_en   <= 1'b1;
                                mem_we_addr <= ls_req_addr;
                                mem_we_data <= ls_req_wdata;
                                mem_we_mask <= ls_req_wmask;
                            end
                        end
                        if (if_win || !if_req_valid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt < STARVE_LIM) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_rd_en   <= 1'b0;
                    mem_rd_addr <= '0;
                    mem_we_en   <= 1'b0;
                    mem_we_addr <= '0;
                    mem_we_data <= '0;
                    mem_we_mask <= '0;
                    if (acc_if) begin
                        if_resp_valid <= 1'b1;
                        if_resp_data  <= mem_rd_data;
                    end else begin
                        ls_resp_valid <= 1'b1;
                        ls_resp_data  <= acc_rd ? mem_rd_data : '0;
                        ls_resp_err   <= acc_err;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (consume) begin
                        if_resp_valid <= 1'b0;
                        if_resp_data  <= '0;
                        ls_resp_valid <= 1'b0;
                        ls_resp_data  <= '0;
                        ls_resp_err   <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
